pulp_clock_sel_ctrl: RTL



---
 rtl/pulp_clock_sel_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pulp_clock_sel_ctrl.sv
// Select sequencer for the two-input glitch-free clock mux.
// Accepts a switch request, waits for the target source to report lock
// (through a synchronizer), flips the mux select, then holds a settle
// window before reporting done. Reports err if the target never locks.
module pulp_clock_sel_ctrl #(
  parameter int   SYNC_STAGES    = 2,
  parameter int   SETTLE_CYCLES  = 16,
  parameter int   TIMEOUT_CYCLES = 1024,
  parameter logic RESET_SEL      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  input  logic lock0_i,
  input  logic lock1_i,
  output logic clk_sel_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic lock_lost_o
);

  localparam int MAX_CNT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    SWITCH    = 2'd2,
    SETTLE    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    clk_sel_q, clk_sel_d;
  logic                    target_q, target_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [SYNC_STAGES-1:0]  lock0_sync_q, lock0_sync_d;
  logic [SYNC_STAGES-1:0]  lock1_sync_q, lock1_sync_d;

  logic lock0_s;
  logic lock1_s;
  logic target_lock;

  // Shift the asynchronous lock inputs into their synchronizer chains.
  always_comb begin
    lock0_sync_d = {lock0_sync_q[SYNC_STAGES-2:0], lock0_i};
    lock1_sync_d = {lock1_sync_q[SYNC_STAGES-2:0], lock1_i};
  end

  assign lock0_s     = lock0_sync_q[SYNC_STAGES-1];
  assign lock1_s     = lock1_sync_q[SYNC_STAGES-1];
  assign target_lock = target_q ? lock1_s : lock0_s;

  // Next-state, counter, select and pulse logic for the switch sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_sel_d = clk_sel_q;
    target_d  = target_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_sel_i == clk_sel_q) begin
            // Already on the requested source: complete immediately.
            done_d = 1'b1;
          end else begin
            target_d = req_sel_i;
            cnt_d    = '0;
            state_d  = WAIT_LOCK;
          end
        end
      end
      WAIT_LOCK: begin
        if (target_lock) begin
          state_d = SWITCH;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SWITCH: begin
        // Sole point where the select moves outside reset.
        clk_sel_d = target_q;
        cnt_d     = '0;
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and synchronizer registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clk_sel_q    <= RESET_SEL;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      lock0_sync_q <= '0;
      lock1_sync_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_sel_q    <= clk_sel_d;
      done_q       <= done_d;
      err_q        <= err_d;
      lock0_sync_q <= lock0_sync_d;
      lock1_sync_q <= lock1_sync_d;
    end
  end

  // Target is only consulted outside IDLE, after it has been loaded.
  always_ff @(posedge clk_i) begin
    target_q <= target_d;
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign clk_sel_o   = clk_sel_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign lock_lost_o = ~(clk_sel_q ? lock1_s : lock0_s);

endmodule
